// File: rtl/filter_select_stage.sv
// Filter-select stage: buttons step a pending filter index, committed to the active index at frame start.
// Define FILTER_SEL_DEBOUNCE_EN to add a DEB_CYC-cycle stability filter on each button.

module filter_select_btn
`ifdef FILTER_SEL_DEBOUNCE_EN
  #(parameter int DEB_CYC = 16)
`endif
(
  input  logic clk,
  input  logic reset,
  input  logic btn_raw_i,
  output logic evt_o
);
  logic s1_q, s2_q, prev_q, prim_q, arm_q, lvl;

  // arm_q stays low until the raw button has been seen released after reset,
  // so a button held through reset never produces an event.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
      prim_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      s1_q   <= btn_raw_i;
      s2_q   <= s1_q;
      prev_q <= lvl;
      prim_q <= 1'b1;
      if (prim_q && !s1_q) arm_q <= 1'b1;
    end
  end

`ifdef FILTER_SEL_DEBOUNCE_EN
  localparam int CNT_W = (DEB_CYC > 1) ? $clog2(DEB_CYC + 1) : 1;
  logic [CNT_W-1:0] cnt_q;
  logic             filt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b0;
    end else if (s2_q == filt_q) begin
      cnt_q  <= '0;
    end else if (cnt_q == CNT_W'(DEB_CYC - 1)) begin
      filt_q <= s2_q;
      cnt_q  <= '0;
    end else begin
      cnt_q  <= cnt_q + 1'b1;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = s2_q;
`endif

  assign evt_o = lvl & ~prev_q & arm_q;
endmodule

module filter_select_stage #(
  parameter  int N_IN             = 5,
  parameter  int DATA_W           = 12,
  parameter  int DEB_CYC          = 16,
  parameter  int COMMIT_IMMEDIATE = 0,
  localparam int SEL_W            = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sel_en,
  input  logic [1:0]             btn,
  input  logic                   frame_start,
  input  logic                   i_de,
  input  logic [N_IN*DATA_W-1:0] i_data,
  output logic [DATA_W-1:0]      o_data,
  output logic                   o_de,
  output logic [SEL_W-1:0]       o_sel,
  output logic [SEL_W-1:0]       o_pending
);
  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

  if (N_IN < 2 || N_IN > 16 || DEB_CYC < 1) begin : g_bad_param
    $error("filter_select_stage: N_IN must be 2..16 and DEB_CYC >= 1");
  end

  logic [1:0] evt;

  for (genvar b = 0; b < 2; b++) begin : g_btn
    filter_select_btn
`ifdef FILTER_SEL_DEBOUNCE_EN
      #(.DEB_CYC(DEB_CYC))
`endif
      u_btn (
        .clk       (clk),
        .reset     (reset),
        .btn_raw_i (btn[b]),
        .evt_o     (evt[b])
      );
  end

  logic [SEL_W-1:0]  pend_q, pend_d, act_q, act_d;
  logic [DATA_W-1:0] data_q, data_d, cand_sel;
  logic              de_q;

  always_comb begin
    pend_d = pend_q;
    if (sel_en && (evt[0] ^ evt[1])) begin
      if (evt[0]) pend_d = (pend_q == LAST)  ? '0   : pend_q + 1'b1;
      else        pend_d = (pend_q == '0)    ? LAST : pend_q - 1'b1;
    end

    // Commit uses the pre-event pending value, so a coincident press lands next frame.
    act_d = act_q;
    if (COMMIT_IMMEDIATE != 0 || frame_start) act_d = pend_q;

    cand_sel = '0;
    for (int k = 0; k < N_IN; k++)
      if (act_q == SEL_W'(k)) cand_sel = i_data[k*DATA_W +: DATA_W];

    data_d = '0;
    if (i_de) data_d = sel_en ? cand_sel : i_data[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q <= '0;
      act_q  <= '0;
      data_q <= '0;
      de_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      act_q  <= act_d;
      data_q <= data_d;
      de_q   <= i_de;
    end
  end

  assign o_data    = data_q;
  assign o_de      = de_q;
  assign o_sel     = act_q;
  assign o_pending = pend_q;
endmodule

// File: tb/tb_filter_select_stage.sv
// Bench for filter_select_stage: directed scenarios plus randomized pixel/button traffic vs an index model.
module tb_filter_select_stage;
  localparam int N = 5;
  localparam int W = 12;
  localparam int DEB = 16;
`ifdef FILTER_SEL_DEBOUNCE_EN
  localparam int EVT_LAT = 3 + DEB;
`else
  localparam int EVT_LAT = 3;
`endif
  localparam int HOLD = EVT_LAT + 3;

  logic           clk = 1'b0;
  logic           reset, sel_en, frame_start, i_de;
  logic [1:0]     btn;
  logic [N*W-1:0] i_data;
  logic [W-1:0]   o_data;
  logic           o_de;
  logic [2:0]     o_sel, o_pending;

  int n_tests = 0;
  int n_fail  = 0;
  int m_pend  = 0;
  int m_act   = 0;
  logic [W-1:0] cand [N];

  always #5 clk = ~clk;

  filter_select_stage #(.N_IN(N), .DATA_W(W), .DEB_CYC(DEB), .COMMIT_IMMEDIATE(0)) dut (
    .clk(clk), .reset(reset), .sel_en(sel_en), .btn(btn), .frame_start(frame_start),
    .i_de(i_de), .i_data(i_data), .o_data(o_data), .o_de(o_de), .o_sel(o_sel),
    .o_pending(o_pending)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_cand();
    for (int k = 0; k < N; k++) i_data[k*W +: W] = cand[k];
  endtask

  task automatic press(input logic [1:0] m, input int hold);
    btn = m;
    repeat (hold) tick();
    btn = 2'b00;
    repeat (hold) tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_act = m_pend;
  endtask

  task automatic test_reset();
    reset = 1'b0; sel_en = 1'b1; i_de = 1'b1; btn = 2'b00; frame_start = 1'b0;
    for (int k = 0; k < N; k++) cand[k] = W'((k + 1) * 256);
    load_cand();
    repeat (3) tick();
    n_tests++; if (o_data !== 12'h000 || o_de !== 1'b0) begin n_fail++;
      $display("FAIL reset_out: o_data=%h o_de=%b, want 000/0", o_data, o_de); end
    n_tests++; if (o_sel !== 3'd0 || o_pending !== 3'd0) begin n_fail++;
      $display("FAIL reset_sel: o_sel=%0d o_pending=%0d, want 0/0", o_sel, o_pending); end
    reset = 1'b1;
    tick();
    n_tests++; if (o_data !== 12'h100 || o_de !== 1'b1 || o_sel !== 3'd0) begin n_fail++;
      $display("FAIL first_pixel: o_data=%h o_de=%b o_sel=%0d, want 100/1/0", o_data, o_de, o_sel); end
  endtask

  task automatic test_next();
    int seq [6] = '{1, 2, 3, 4, 0, 1};
    for (int i = 0; i < 6; i++) begin
      press(2'b01, HOLD);
      m_pend = (m_pend + 1) % N;
      n_tests++; if (o_pending !== 3'(seq[i]) || o_pending !== 3'(m_pend)) begin n_fail++;
        $display("FAIL next_%0d: o_pending=%0d, want %0d", i, o_pending, seq[i]); end
      n_tests++; if (o_sel !== 3'd0) begin n_fail++;
        $display("FAIL next_hold_%0d: o_sel=%0d, want 0", i, o_sel); end
    end
    frame();
    n_tests++; if (o_sel !== 3'd1) begin n_fail++;
      $display("FAIL commit: o_sel=%0d, want 1", o_sel); end
    tick();
    n_tests++; if (o_data !== 12'h200) begin n_fail++;
      $display("FAIL commit_data: o_data=%h, want 200", o_data); end
  endtask

  task automatic test_prev();
    press(2'b10, HOLD); m_pend = (m_pend + N - 1) % N;
    n_tests++; if (o_pending !== 3'd0) begin n_fail++;
      $display("FAIL prev_to0: o_pending=%0d, want 0", o_pending); end
    press(2'b10, HOLD); m_pend = (m_pend + N - 1) % N;
    n_tests++; if (o_pending !== 3'd4) begin n_fail++;
      $display("FAIL prev_wrap: o_pending=%0d, want 4", o_pending); end
    press(2'b11, HOLD);
    n_tests++; if (o_pending !== 3'd4) begin n_fail++;
      $display("FAIL both_btn: o_pending=%0d, want 4", o_pending); end
  endtask

  task automatic test_coincide();
    repeat (3) begin press(2'b01, HOLD); m_pend = (m_pend + 1) % N; end
    n_tests++; if (o_pending !== 3'd2) begin n_fail++;
      $display("FAIL coin_setup: o_pending=%0d, want 2", o_pending); end
    btn = 2'b01;
    repeat (EVT_LAT - 1) tick();
    frame();
    m_pend = (m_pend + 1) % N;
    n_tests++; if (o_sel !== 3'd2 || o_pending !== 3'd3) begin n_fail++;
      $display("FAIL coincide: o_sel=%0d o_pending=%0d, want 2/3", o_sel, o_pending); end
    btn = 2'b00;
    repeat (HOLD) tick();
    frame();
    n_tests++; if (o_sel !== 3'd3) begin n_fail++;
      $display("FAIL coin_next: o_sel=%0d, want 3", o_sel); end
  endtask

  task automatic test_sel_en();
    sel_en = 1'b0;
    tick();
    n_tests++; if (o_data !== cand[0]) begin n_fail++;
      $display("FAIL bypass: o_data=%h, want %h", o_data, cand[0]); end
    press(2'b01, HOLD);
    n_tests++; if (o_pending !== 3'(m_pend)) begin n_fail++;
      $display("FAIL disabled_btn: o_pending=%0d, want %0d", o_pending, m_pend); end
    sel_en = 1'b1;
    tick();
    n_tests++; if (o_data !== cand[m_act]) begin n_fail++;
      $display("FAIL reenable: o_data=%h, want %h", o_data, cand[m_act]); end
    i_de = 1'b0;
    tick();
    n_tests++; if (o_data !== 12'h000 || o_de !== 1'b0) begin n_fail++;
      $display("FAIL blank: o_data=%h o_de=%b, want 000/0", o_data, o_de); end
    i_de = 1'b1;
  endtask

  task automatic test_random();
    logic [1:0]   m;
    logic [W-1:0] exp_d;
    logic         exp_de;
    for (int r = 0; r < 8; r++) begin
      m = 2'($urandom_range(1, 3));
      sel_en = ($urandom_range(0, 3) != 0);
      press(m, HOLD);
      if (sel_en && m == 2'b01) m_pend = (m_pend + 1) % N;
      if (sel_en && m == 2'b10) m_pend = (m_pend + N - 1) % N;
      n_tests++; if (o_pending !== 3'(m_pend)) begin n_fail++;
        $display("FAIL rnd_pend_%0d: o_pending=%0d, want %0d", r, o_pending, m_pend); end
      for (int c = 0; c < 25; c++) begin
        for (int k = 0; k < N; k++) cand[k] = W'($urandom_range(0, 4095));
        load_cand();
        sel_en = ($urandom_range(0, 3) != 0);
        i_de = ($urandom_range(0, 3) != 0);
        frame_start = ($urandom_range(0, 7) == 0);
        exp_d = !i_de ? '0 : (sel_en ? cand[m_act] : cand[0]);
        exp_de = i_de;
        if (frame_start) m_act = m_pend;
        tick();
        frame_start = 1'b0;
        n_tests++; if (o_data !== exp_d || o_de !== exp_de) begin n_fail++;
          $display("FAIL rnd_data_%0d_%0d: o_data=%h o_de=%b, want %h/%b", r, c, o_data, o_de, exp_d, exp_de); end
        n_tests++; if (o_sel !== 3'(m_act)) begin n_fail++;
          $display("FAIL rnd_sel_%0d_%0d: o_sel=%0d, want %0d", r, c, o_sel, m_act); end
      end
    end
    sel_en = 1'b1; i_de = 1'b1;
  endtask

  task automatic test_debounce();
`ifdef FILTER_SEL_DEBOUNCE_EN
    btn = 2'b01; repeat (10) tick();
    btn = 2'b00; repeat (30) tick();
    n_tests++; if (o_pending !== 3'(m_pend)) begin n_fail++;
      $display("FAIL glitch: o_pending=%0d, want %0d", o_pending, m_pend); end
    btn = 2'b01; repeat (20) tick();
    btn = 2'b00; repeat (30) tick();
    m_pend = (m_pend + 1) % N;
    n_tests++; if (o_pending !== 3'(m_pend)) begin n_fail++;
      $display("FAIL deb_press: o_pending=%0d, want %0d", o_pending, m_pend); end
`endif
  endtask

  task automatic test_reset_mid();
    while (m_pend != 3) begin press(2'b01, HOLD); m_pend = (m_pend + 1) % N; end
    frame();
    n_tests++; if (o_sel !== 3'd3) begin n_fail++;
      $display("FAIL mid_setup: o_sel=%0d, want 3", o_sel); end
    repeat (4) begin i_de = ~i_de; tick(); end
    i_de = 1'b1; btn = 2'b01; reset = 1'b0;
    tick();
    m_pend = 0; m_act = 0;
    n_tests++; if (o_data !== 12'h000 || o_de !== 1'b0 || o_sel !== 3'd0 || o_pending !== 3'd0) begin n_fail++;
      $display("FAIL mid_reset: o_data=%h o_de=%b o_sel=%0d o_pending=%0d, want 000/0/0/0",
               o_data, o_de, o_sel, o_pending); end
    repeat (2) tick();
    reset = 1'b1;
    repeat (2 * HOLD) tick();
    n_tests++; if (o_pending !== 3'd0) begin n_fail++;
      $display("FAIL held_through_reset: o_pending=%0d, want 0", o_pending); end
    btn = 2'b00; repeat (HOLD) tick();
    press(2'b01, HOLD); m_pend = 1;
    n_tests++; if (o_pending !== 3'd1) begin n_fail++;
      $display("FAIL repress: o_pending=%0d, want 1", o_pending); end
  endtask

  initial begin
    test_reset();
    test_next();
    test_prev();
    test_coincide();
    test_sel_en();
    test_debounce();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
